// File: rtl/mmio_regfile_lite.sv
// AXI4-Lite MMIO register file: parametrised RW/RO banks, byte-strobe writes,
// per-register write pulses and a sticky, maskable interrupt block.
module mmio_regfile_lite #(
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          AW        = 4,
    parameter int          NUM_RW    = 8,
    parameter int          NUM_RO    = 4,
    parameter int          NUM_IRQ   = 4
) (
    input  logic                  fclk,
    input  logic                  rst,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [31:0]           s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [32*NUM_RW-1:0]  reg_out,
    output logic [NUM_RW-1:0]     wr_pulse,
    input  logic [32*NUM_RO-1:0]  ro_in,
    input  logic [NUM_IRQ-1:0]    irq_src,
    output logic                  irq
);

    localparam logic [AW-1:0] IDX_ENABLE  = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_STATUS  = {{(AW-1){1'b1}}, 1'b0};
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    logic                 aw_held_reg;
    logic [31:2]          awaddr_reg;
    logic                 w_held_reg;
    logic [31:0]          wdata_reg;
    logic [3:0]           wstrb_reg;
    logic                 bvalid_reg;
    logic [1:0]           bresp_reg;
    logic                 rvalid_reg;
    logic [1:0]           rresp_reg;
    logic [31:0]          rdata_reg;
    logic [31:0]          rw_reg [NUM_RW];
    logic [NUM_RW-1:0]    wr_pulse_reg;
    logic [NUM_IRQ-1:0]   irq_status_reg;
    logic [NUM_IRQ-1:0]   irq_enable_reg;
    logic                 irq_reg;

    logic                 unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = !aw_held_reg && !bvalid_reg;
    assign s_wready  = !w_held_reg && !bvalid_reg;
    assign s_bvalid  = bvalid_reg;
    assign s_bresp   = bresp_reg;
    assign s_arready = !rvalid_reg;
    assign s_rvalid  = rvalid_reg;
    assign s_rresp   = rresp_reg;
    assign s_rdata   = rdata_reg;
    assign wr_pulse  = wr_pulse_reg;
    assign irq       = irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RW; gi++) begin : g_reg_out
            assign reg_out[32*gi +: 32] = rw_reg[gi];
        end
    endgenerate

    // ---------------- write path ----------------
    logic              aw_hs, w_hs, commit;
    logic [31:2]       wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [AW-1:0]     wr_idx;
    logic [31:0]       wr_word;
    logic              wr_in_win, wr_is_rw, wr_ok, wr_en;
    logic [31:0]       byte_mask;
    logic [31:0]       wr_masked;
    logic [NUM_RW-1:0] rw_hit;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [31:0]       enable_merged;

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid && s_wready;
    // Commit as soon as both halves are available, whether held or arriving now.
    assign commit = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

    assign wr_addr = aw_held_reg ? awaddr_reg : s_awaddr[31:2];
    assign wr_data = w_held_reg ? wdata_reg : s_wdata;
    assign wr_strb = w_held_reg ? wstrb_reg : s_wstrb;

    assign wr_in_win = (wr_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign wr_idx    = wr_addr[AW+1:2];
    assign wr_word   = 32'(wr_idx);
    assign wr_is_rw  = wr_word < 32'(NUM_RW);
    assign wr_ok     = wr_in_win && (wr_is_rw || wr_idx == IDX_STATUS || wr_idx == IDX_ENABLE);
    assign wr_en     = commit && wr_ok;

    assign byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_masked = wr_data & byte_mask;

    always_comb begin
        rw_hit = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_hit[i] = wr_en && (wr_word == 32'(i));
        end
    end

    assign irq_clr       = (wr_en && wr_idx == IDX_STATUS) ? wr_masked[NUM_IRQ-1:0] : '0;
    assign enable_merged = (32'(irq_enable_reg) & ~byte_mask) | wr_masked;

    always_ff @(posedge fclk) begin
        if (rst) begin
            aw_held_reg <= 1'b0;
            awaddr_reg  <= '0;
            w_held_reg  <= 1'b0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else if (commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_awaddr[31:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_wdata;
                wstrb_reg  <= s_wstrb;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_reg && s_bready) begin
            bvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            wr_pulse_reg <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                rw_reg[i] <= '0;
            end
        end else begin
            wr_pulse_reg <= rw_hit;
            for (int i = 0; i < NUM_RW; i++) begin
                if (rw_hit[i]) begin
                    rw_reg[i] <= (rw_reg[i] & ~byte_mask) | wr_masked;
                end
            end
        end
    end

    // ---------------- interrupts ----------------
    always_ff @(posedge fclk) begin
        if (rst) begin
            irq_status_reg <= '0;
            irq_enable_reg <= '0;
            irq_reg        <= 1'b0;
        end else begin
            irq_status_reg <= (irq_status_reg & ~irq_clr) | irq_src;
            if (wr_en && wr_idx == IDX_ENABLE) begin
                irq_enable_reg <= enable_merged[NUM_IRQ-1:0];
            end
            irq_reg <= |(irq_status_reg & irq_enable_reg);
        end
    end

    // ---------------- read path ----------------
    logic          ar_hs;
    logic          rd_in_win, rd_ok;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [31:0]   rd_val;

    assign ar_hs     = s_arvalid && !rvalid_reg;
    assign rd_in_win = (s_araddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign rd_idx    = s_araddr[AW+1:2];
    assign rd_word   = 32'(rd_idx);

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        if (rd_in_win) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (rd_word == 32'(i)) begin
                    rd_val = rw_reg[i];
                    rd_ok  = 1'b1;
                end
            end
            for (int i = 0; i < NUM_RO; i++) begin
                if (rd_word == 32'(NUM_RW + i)) begin
                    rd_val = ro_in[32*i +: 32];
                    rd_ok  = 1'b1;
                end
            end
            if (rd_idx == IDX_STATUS) begin
                rd_val = 32'(irq_status_reg);
                rd_ok  = 1'b1;
            end
            if (rd_idx == IDX_ENABLE) begin
                rd_val = 32'(irq_enable_reg);
                rd_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_reg  <= rd_ok ? rd_val : 32'h0;
        end else if (rvalid_reg && s_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_regfile_lite.sv
// Directed bench for mmio_regfile_lite: expected responses are queued at issue
// time and checked when the DUT presents them.
module tb_mmio_regfile_lite;

    localparam logic [31:0] BASE = 32'h7000_0000;

    logic          fclk = 1'b0;
    logic          rst;
    logic [31:0]   s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [31:0]   s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [255:0]  reg_out;
    logic [7:0]    wr_pulse;
    logic [127:0]  ro_in;
    logic [3:0]    irq_src;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  bq [$];
    logic [1:0]  rq_resp [$];
    logic [31:0] rq_data [$];
    logic [31:0] exp_rw [8];

    always #5 fclk = ~fclk;

    mmio_regfile_lite dut (
        .fclk(fclk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .ro_in(ro_in),
        .irq_src(irq_src), .irq(irq)
    );

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [255:0] expv;
        for (int i = 0; i < 8; i++) expv[32*i +: 32] = exp_rw[i];
        n_cmp++;
        assert (reg_out === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, reg_out, expv);
        end
    endtask

    // mode 0: AW then W gap cycles later; 1: W then AW; 2: same cycle
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input int gap,
                             input logic [1:0] exp_resp, input logic [7:0] exp_pulse, input int stall);
        logic [1:0] eb;
        bq.push_back(exp_resp);
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        if (mode == 0) begin
            s_awvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
            chk({tag, "_awready_held"}, 32'(s_awready), 32'h0);
            repeat (gap - 1) tick();
            s_wvalid = 1'b1;
            tick();
            s_wvalid = 1'b0;
        end else if (mode == 1) begin
            s_wvalid = 1'b1;
            tick();
            s_wvalid = 1'b0;
            chk({tag, "_wready_held"}, 32'(s_wready), 32'h0);
            repeat (gap - 1) tick();
            s_awvalid = 1'b1;
            tick();
            s_awvalid = 1'b0;
        end else begin
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            tick();
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end
        chk({tag, "_bvalid"}, 32'(s_bvalid), 32'h1);
        chk({tag, "_pulse"}, 32'(wr_pulse), 32'(exp_pulse));
        eb = bq.pop_front();
        chk({tag, "_bresp"}, 32'(s_bresp), 32'(eb));
        for (int c = 0; c < stall; c++) begin
            tick();
            chk({tag, "_stall_b"}, {28'h0, s_bvalid, s_bresp, s_awready | s_wready}, {28'h0, 1'b1, eb, 1'b0});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk({tag, "_bdone"}, {29'h0, s_bvalid, s_awready, s_wready}, 32'h3);
        chk({tag, "_pulse_end"}, 32'(wr_pulse), 32'h0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int stall);
        logic [31:0] ed;
        logic [1:0]  er;
        rq_data.push_back(exp_data);
        rq_resp.push_back(exp_resp);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'h1);
        ed = rq_data.pop_front();
        er = rq_resp.pop_front();
        chk({tag, "_rdata"}, s_rdata, ed);
        chk({tag, "_rresp"}, 32'(s_rresp), 32'(er));
        for (int c = 0; c < stall; c++) begin
            tick();
            chk({tag, "_stall_rdata"}, s_rdata, ed);
            chk({tag, "_stall_r"}, {30'h0, s_rvalid, s_arready}, 32'h2);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk({tag, "_rdone"}, {30'h0, s_rvalid, s_arready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        ro_in = '0; irq_src = '0;
        for (int i = 0; i < 8; i++) exp_rw[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset_ready", {29'h0, s_awready, s_wready, s_arready}, 32'h7);
        chk("reset_valid", {30'h0, s_bvalid, s_rvalid}, 32'h0);
        chk("reset_irq_pulse", {23'h0, irq, wr_pulse}, 32'h0);
        chk_regs("reset_regs");
        axi_read("rd_idx0", BASE + 32'h0, 32'h0, 2'b00, 0);

        axi_write("wr_aw_first", BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 3, 2'b00, 8'h04, 0);
        exp_rw[2] = 32'hDEADBEEF;
        chk_regs("regs_after_aw_first");
        axi_write("wr_w_first", BASE + 32'hC, 32'h12345678, 4'hF, 1, 3, 2'b00, 8'h08, 0);
        exp_rw[3] = 32'h12345678;
        axi_write("wr_same", BASE + 32'h10, 32'hCAFEF00D, 4'hF, 2, 1, 2'b00, 8'h10, 0);
        exp_rw[4] = 32'hCAFEF00D;
        chk_regs("regs_after_three");

        axi_write("wr_strb", BASE + 32'h8, 32'h11223344, 4'b0101, 2, 1, 2'b00, 8'h04, 0);
        exp_rw[2] = 32'hDE22BE44;
        axi_read("rd_strb", BASE + 32'h8, 32'hDE22BE44, 2'b00, 0);
        axi_write("wr_strb0", BASE + 32'h0, 32'hFFFFFFFF, 4'h0, 2, 1, 2'b00, 8'h01, 0);

        axi_write("wr_ro", BASE + 32'h20, 32'hAAAA5555, 4'hF, 2, 1, 2'b10, 8'h00, 0);
        axi_write("wr_unmapped", BASE + 32'h30, 32'hAAAA5555, 4'hF, 0, 2, 2'b10, 8'h00, 0);
        axi_write("wr_out_win", BASE + 32'h1000, 32'hAAAA5555, 4'hF, 1, 2, 2'b10, 8'h00, 0);
        chk_regs("regs_after_slverr");

        ro_in = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
        axi_read("rd_ro1", BASE + 32'h24, 32'h22220002, 2'b00, 0);
        axi_read("rd_unmapped", BASE + 32'h34, 32'h0, 2'b10, 0);
        axi_read("rd_out_win", BASE + 32'h1010, 32'h0, 2'b10, 0);

        axi_read("rd_stall", BASE + 32'h10, 32'hCAFEF00D, 2'b00, 5);
        axi_write("wr_stall", BASE + 32'h1C, 32'h0BADF00D, 4'hF, 2, 1, 2'b00, 8'h80, 5);
        exp_rw[7] = 32'h0BADF00D;
        chk_regs("regs_after_stall");

        axi_write("wr_en_all", BASE + 32'h3C, 32'hFFFFFFFF, 4'hF, 2, 1, 2'b00, 8'h00, 0);
        axi_read("rd_en_all", BASE + 32'h3C, 32'h0000000F, 2'b00, 0);
        axi_write("wr_en1", BASE + 32'h3C, 32'h00000001, 4'hF, 2, 1, 2'b00, 8'h00, 0);

        irq_src = 4'h1;
        tick();
        irq_src = 4'h0;
        chk("irq_after_1", 32'(irq), 32'h0);
        tick();
        chk("irq_after_2", 32'(irq), 32'h1);
        repeat (3) tick();
        chk("irq_sticky", 32'(irq), 32'h1);
        axi_read("rd_status", BASE + 32'h38, 32'h1, 2'b00, 0);

        axi_write("w1c_low", BASE + 32'h38, 32'h1, 4'hF, 2, 1, 2'b00, 8'h00, 0);
        chk("irq_cleared", 32'(irq), 32'h0);
        axi_read("rd_status_clr", BASE + 32'h38, 32'h0, 2'b00, 0);

        irq_src = 4'h1;
        repeat (2) tick();
        chk("irq_held_src", 32'(irq), 32'h1);
        axi_write("w1c_high", BASE + 32'h38, 32'h1, 4'hF, 2, 1, 2'b00, 8'h00, 0);
        tick();
        chk("irq_set_wins", 32'(irq), 32'h1);
        axi_read("rd_status_set", BASE + 32'h38, 32'h1, 2'b00, 0);
        irq_src = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_regfile_lite.md
# mmio_regfile_lite

Parametrised AXI4-Lite MMIO register file. It is the successor to the fixed-map camera MMIO slave and sits behind the AXI-to-lite converter on the PS general-purpose port. It provides:
- a configurable number of read/write and read-only 32-bit registers;
- byte-strobe writes;
- independent AW/W acceptance;
- per-register write pulses;
- a sticky, maskable interrupt block.

## Interface
Parameters:
- BASE_ADDR, 32'h7000_0000: byte base of window; must be aligned to 4·2^AW
- AW, 4: word-address bits; window = 2^AW words
- NUM_RW, 8: RW registers at word index 0..NUM_RW-1
- NUM_RO, 4: RO registers at word index NUM_RW..NUM_RW+NUM_RO-1; NUM_RW+NUM_RO ≤ 2^AW-2
- NUM_IRQ, 4: interrupt sources, 1..32

Ports:
- fclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_awaddr  in  32  write address
- s_awvalid  in  1
- s_awready  out  1
- s_wdata  in  32
- s_wstrb  in  4
- s_wvalid  in  1
- s_wready  out  1
- s_bresp  out  2
- s_bvalid  out  1
- s_bready  in  1
- s_araddr  in  32
- s_arvalid  in  1
- s_arready  out  1
- s_rdata  out  32
- s_rresp  out  2
- s_rvalid  out  1
- s_rready  in  1
- reg_out  out  32·NUM_RW  RW register contents; register i = bits [32i+31:32i]
- wr_pulse  out  NUM_RW  one-cycle strobe per RW register written
- ro_in  in  32·NUM_RO  RO register sources, sampled at read accept
- irq_src  in  NUM_IRQ  level interrupt sources
- irq  out  1  registered, |(IRQ_STATUS & IRQ_ENABLE)

## Operation
Decode:
- Address is in-window when addr[31:AW+2] == BASE_ADDR[31:AW+2]; addr[1:0] are ignored. Word index = addr[AW+1:2].
- Word index 2^AW-2 is IRQ_STATUS: sticky, write-1-to-clear.
- Word index 2^AW-1 is IRQ_ENABLE: RW; only bits [NUM_IRQ-1:0] are stored, upper bits read 0.
- The response is SLVERR for any of: out of window, unmapped index, or a write to an RO index. SLVERR writes change no state and produce no wr_pulse. SLVERR reads return rdata 0.

Write path:
- AW and W are captured independently into holding registers (aw_held, w_held), in either order or in the same cycle.
- s_awready = !aw_held && !s_bvalid. s_wready = !w_held && !s_bvalid.
- Commit happens on the edge where both the address and the data are held, or arrive on that edge. On commit:
  - each byte k with s_wstrb[k]=1 updates;
  - wr_pulse[i] is set for an OKAY write to RW register i, even when wstrb = 0;
  - bresp is latched and s_bvalid is set;
  - both holding registers are cleared.
- s_bvalid stays high until s_bready; the handshake returns AXI to accepting.

Read path:
- s_arready = !s_rvalid.
- On AR handshake, s_rdata and s_rresp are latched and s_rvalid is set. s_rvalid holds until s_rready.
- Only one read is outstanding at a time.

IRQ:
- Each cycle: status ← (status & ~clr) | irq_src.
- clr is the byte-masked write data of an IRQ_STATUS commit.
- Set wins over clear in the same cycle.
- irq is registered from status & enable.

## Timing
- Reset values: reg_out 0, wr_pulse 0, IRQ_STATUS 0, IRQ_ENABLE 0, irq 0, s_bvalid 0, s_rvalid 0, s_bresp 0, s_rresp 0, s_rdata 0, s_awready 1, s_wready 1, s_arready 1.
- Holding registers clear on reset.
- Reset mid-transaction drops it: no response is issued.
- Write latency: reg_out and wr_pulse update on the commit edge. s_bvalid is high in the cycle after the last AW/W handshake. wr_pulse is high for exactly that one cycle.
- Read latency: s_rvalid is high in the cycle after the AR handshake. Maximum throughput is 1 read per 2 cycles with s_rready tied high.
- A read and a write committing to the same register on the same edge: the read returns the old value.
- Read and write paths are fully concurrent.
- irq follows an irq_src rise by 2 cycles (status, then irq) when enabled.

## Test plan
- Reset → all ready signals 1, all valids 0, reg_out 0, irq 0. Read index 0 → 0x0, OKAY.
- AW to BASE+0x8, W 0xDEADBEEF (strb 0xF) 3 cycles later → reg 2 = 0xDEADBEEF, wr_pulse[2] high 1 cycle, BVALID 1 cycle after W, OKAY. Repeat with W before AW, then with both in the same cycle.
- Write 0x11223344 with strb 0b0101 over 0xDEADBEEF → readback 0xDE22BE44.
- Write to an RO index, to an unmapped index, and to BASE+0x1000 → SLVERR, reg_out unchanged, no wr_pulse. Read of an RO index → current ro_in value.
- Hold BREADY/RREADY low 5 cycles → BVALID/RVALID and data stable; AWREADY/WREADY/ARREADY low until the handshake.
- IRQ_ENABLE=0x1, pulse irq_src[0] 1 cycle → irq=1 two cycles later and stays high.
- W1C 0x1 to IRQ_STATUS with irq_src[0] low → irq drops. Repeat with irq_src[0] held high → status stays 1.
